// File: rtl/add_pkg.sv
// Shared mode encoding and default geometry for the pipelined adder.
package add_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Slice 0 carry-in: subtraction is A + ~B + 1.
  function automatic logic carry_in(input mode_e m);
    return (m == SUB);
  endfunction

endpackage

// File: rtl/add_slice.sv
// One SW-bit ripple slice; also exposes the carry into its MSB so the
// top slice can derive signed overflow.
module add_slice
  import add_pkg::*;
#(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          msb_cin
);

  logic [SW:0] sum;

  // Slice sum with carry-out in the extra bit.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    s       = sum[SW-1:0];
    cout    = sum[SW];
    msb_cin = a[SW-1] ^ b[SW-1] ^ sum[SW-1];
  end

endmodule

// File: rtl/add_pipe.sv
// Carry-pipelined adder/subtractor: one SW-bit slice per stage, operand
// slices skewed in, result slices deskewed out, global stall on backpressure.
module add_pipe
  import add_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW = WIDTH / STAGES;

  mode_e             mode;
  logic              en;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  res;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic              m_q;

  // Effective B operand: inverted for subtraction.
  always_comb begin
    mode  = sub ? SUB : ADD;
    b_eff = (mode == SUB) ? ~In2 : In2;
  end

  // The whole pipe advances together unless the output is blocked.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Per-stage valid bits; bubbles shift through like data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else if (en) begin
      v_q[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    localparam int unsigned DEPTH = j;
    localparam int unsigned ALIGN = STAGES - 1 - j;

    logic [SW-1:0] a_s, b_s, s_w, r_q;
    logic          cin_w, co_w, msb_w, c_r;

    if (j == 0) begin : g_head
      assign a_s   = In1[SW-1:0];
      assign b_s   = b_eff[SW-1:0];
      assign cin_w = carry_in(mode);
    end else begin : g_skew
      logic [SW-1:0] da [DEPTH];
      logic [SW-1:0] db [DEPTH];

      // Delay this slice's operands until the lower carry reaches it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned d = 0; d < DEPTH; d++) begin
            da[d] <= '0;
            db[d] <= '0;
          end
        end else if (en) begin
          da[0] <= In1[j*SW +: SW];
          db[0] <= b_eff[j*SW +: SW];
          for (int unsigned d = 1; d < DEPTH; d++) begin
            da[d] <= da[d-1];
            db[d] <= db[d-1];
          end
        end
      end

      assign a_s   = da[DEPTH-1];
      assign b_s   = db[DEPTH-1];
      assign cin_w = c_q[j-1];
    end

    add_slice #(.SW(SW)) u_slice (
      .a       (a_s),
      .b       (b_s),
      .cin     (cin_w),
      .s       (s_w),
      .cout    (co_w),
      .msb_cin (msb_w)
    );

    // Stage register: slice result and carry handed to the next slice.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
        c_r <= 1'b0;
      end else if (en) begin
        r_q <= s_w;
        c_r <= co_w;
      end
    end

    assign c_q[j] = c_r;

    if (j == STAGES - 1) begin : g_tail
      // Carry into the top bit, paired with c_q for the overflow test.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_q <= 1'b0;
        end else if (en) begin
          m_q <= msb_w;
        end
      end

      assign res[j*SW +: SW] = r_q;
    end else begin : g_align
      logic          msb_unused;
      logic [SW-1:0] dr [ALIGN];

      assign msb_unused = msb_w;

      // Hold finished lower slices until the top slice catches up.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned d = 0; d < ALIGN; d++) begin
            dr[d] <= '0;
          end
        end else if (en) begin
          dr[0] <= r_q;
          for (int unsigned d = 1; d < ALIGN; d++) begin
            dr[d] <= dr[d-1];
          end
        end
      end

      assign res[j*SW +: SW] = dr[ALIGN-1];
    end
  end

  // Output view of the last stage; zero only flags a valid result.
  always_comb begin
    out_valid = v_q[STAGES-1];
    OUT       = res;
    cout      = c_q[STAGES-1];
    ovf       = m_q ^ c_q[STAGES-1];
    zero      = out_valid && (res == '0);
  end

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sub = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;

  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] out;
  logic        iv_x;
  logic        ir1, ov1, c1, o1, z1;
  logic [31:0] out1;
  logic        ir2, ov2, c2, o2, z2;
  logic [15:0] out2;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [34:0] q0[$];
  logic [34:0] q1[$];
  logic [34:0] q2[$];
  int          pop_cyc[$];
  logic        hold_v = 1'b0;
  logic [34:0] hold_val;
  logic        rnd_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference instances see exactly the operations the main DUT accepts.
  assign iv_x = in_valid && in_ready;

  add_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .In1(in1), .In2(in2), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .OUT(out), .cout(cout), .ovf(ovf), .zero(zero)
  );

  add_pipe #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(ir1),
    .In1(in1), .In2(in2), .sub(sub), .out_valid(ov1),
    .out_ready(1'b1), .OUT(out1), .cout(c1), .ovf(o1), .zero(z1)
  );

  add_pipe #(.WIDTH(16), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(ir2),
    .In1(in1[15:0]), .In2(in2[15:0]), .sub(sub), .out_valid(ov2),
    .out_ready(1'b1), .OUT(out2), .cout(c2), .ovf(o2), .zero(z2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Packs {zero, ovf, cout, out}.
  function automatic logic [34:0] er(input logic z, input logic o, input logic c,
                                     input logic [31:0] r);
    return {z, o, c, r};
  endfunction

  // Whole-word reference for a w-bit adder.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input int w);
    logic [31:0] mask, am, bm, o;
    logic [33:0] full;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = a & mask;
    bm   = (s ? ~b : b) & mask;
    full = {2'b00, am} + {2'b00, bm} + {33'd0, s};
    o    = full[31:0] & mask;
    return {(o == 32'd0), (am[w-1] == bm[w-1]) && (o[w-1] != am[w-1]), full[w], o};
  endfunction

  task automatic push_all(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [34:0] e0);
    q0.push_back(e0);
    q1.push_back(model(a, b, s, 32));
    q2.push_back(model(a, b, s, 16));
  endtask

  // Present one operation from posedge+1 and hold it until accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [34:0] e0);
    logic r;
    r = 1'b0;
    in1 = a; in2 = b; sub = s; in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    chk("accepted", r, 1);
    if (r) push_all(a, b, s, e0);
  endtask

  // Single beat into an empty pipe; counts cycles until each instance answers.
  task automatic lat(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [34:0] e0);
    int l0, l1, l2;
    l0 = 0; l1 = 0; l2 = 0;
    chk("lat_ready", in_ready, 1);
    in1 = a; in2 = b; sub = s; in_valid = 1'b1;
    push_all(a, b, s, e0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (l0 == 0 && out_valid) l0 = n;
      if (l1 == 0 && ov1) l1 = n;
      if (l2 == 0 && ov2) l2 = n;
      @(posedge clk);
    end
    #1;
    chk("lat_s4", l0, 4);
    chk("lat_s1", l1, 1);
    chk("lat_s2", l2, 2);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (q0.size() + q1.size() + q2.size()) != 0; t++)
      @(posedge clk);
    #1 chk("drain", q0.size() + q1.size() + q2.size(), 0);
  endtask

  // Main scoreboard, handshake rule and stall stability.
  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst) begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid && !out_ready) begin
        if (hold_v) chk("hold", {zero, ovf, cout, out}, hold_val);
        hold_v   = 1'b1;
        hold_val = {zero, ovf, cout, out};
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk("sb0_pending", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("out", out, e[31:0]);
          chk("cout", cout, e[32]);
          chk("ovf", ovf, e[33]);
          chk("zero", zero, e[34]);
          pop_cyc.push_back(cyc);
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Scoreboards for the STAGES=1 and WIDTH=16 instances.
  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst && ov1) begin
      chk("sb1_pending", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("s1_res", {z1, o1, c1, out1}, e);
      end
    end
    if (!rst && ov2) begin
      chk("sb2_pending", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("s2_res", {z2, o2, c2, 16'h0000, out2}, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    logic [31:0] a, b;
    logic s;

    // Reset state, asserted asynchronously between edges.
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat 1+3, latency per instance.
    lat(32'd1, 32'd3, 1'b0, er(0, 0, 0, 32'd4));
    drain();

    // Back-to-back add/sub corner cases.
    pop_cyc.delete();
    send(32'd10, 32'd6, 1'b0, er(0, 0, 0, 32'd16));
    send(32'hFFFF_FFFF, 32'd1, 1'b0, er(1, 0, 1, 32'h0000_0000));
    send(32'h7FFF_FFFF, 32'd1, 1'b0, er(0, 1, 0, 32'h8000_0000));
    send(32'd5, 32'd7, 1'b1, er(0, 0, 0, 32'hFFFF_FFFE));
    send(32'h8000_0000, 32'd1, 1'b1, er(0, 1, 1, 32'h7FFF_FFFF));
    in_valid = 1'b0;
    drain();
    chk("b2b_pops", pop_cyc.size(), 5);
    if (pop_cyc.size() == 5) chk("b2b_span", pop_cyc[4] - pop_cyc[0], 4);

    // Eight-op stream with a three-cycle output stall.
    pop_cyc.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(i, 32'd100, 1'b0, er(0, 0, 0, 32'd100 + i));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_pops", pop_cyc.size(), 8);

    // Reset with three operations in flight.
    send(32'd20, 32'd1, 1'b0, er(0, 0, 0, 32'd21));
    send(32'd21, 32'd1, 1'b0, er(0, 0, 0, 32'd22));
    send(32'd22, 32'd1, 1'b0, er(0, 0, 0, 32'd23));
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_out", out, 0);
    chk("rst_mid_ready", in_ready, 1);
    q0.delete(); q1.delete(); q2.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
      @(posedge clk);
    end
    #1 chk("no_stale", stale, 0);
    lat(32'd7, 32'd9, 1'b0, er(0, 0, 0, 32'd16));
    drain();

    // Random operations against the model with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + $urandom_range(0, 31) : $urandom;
          b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom;
          s = 1'($urandom_range(0, 1));
          send(a, b, s, model(a, b, s, 32));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
